// File: rtl/uart_fracbaud_gen.sv
// uart_fracbaud_gen: fractional baud-rate generator for the UART core.
// Emits a one-cycle oversample tick at an average rate of
// clk / (divisor + frac/2^FRAC_WIDTH) and a one-cycle bit tick every OSR
// oversample ticks. New divisor/fraction settings pass through a shadow
// register and take effect on an oversample tick boundary.
// Optional feature macro: UART_FRACBAUD_RESYNC_EN adds i_resync, which restarts
// the phase so RX can align to a start bit.
module uart_fracbaud_gen #(
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_WIDTH   = 4,
    parameter int OSR          = 16,
    parameter int DEFAULT_DIV  = 27,
    parameter int DEFAULT_FRAC = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [DIV_WIDTH-1:0]    i_divisor,
    input  logic [FRAC_WIDTH-1:0]   i_frac,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic                    i_baud_os_en,
    input  logic                    i_baud_en,
`ifdef UART_FRACBAUD_RESYNC_EN
    input  logic                    i_resync,
`endif
    output logic                    o_baud_os,
    output logic                    o_baud,
    output logic [$clog2(OSR)-1:0]  o_os_count
);

    localparam int OSW = $clog2(OSR);

    logic [DIV_WIDTH-1:0]  div_a, div_s, div_eff;
    logic [FRAC_WIDTH-1:0] frac_a, frac_s, acc;
    logic                  carry;
    logic                  pending;
    logic [DIV_WIDTH:0]    count, len_m1;
    logic [FRAC_WIDTH:0]   acc_sum;
    logic                  resync, expire, apply;

`ifdef UART_FRACBAUD_RESYNC_EN
    assign resync = i_resync;
`else
    assign resync = 1'b0;
`endif

    // Divisors below 2 would allow back-to-back ticks, so they run as 2.
    assign div_eff = (div_a < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_a;
    assign len_m1  = {1'b0, div_eff} + {{DIV_WIDTH{1'b0}}, carry} - (DIV_WIDTH+1)'(1);
    assign acc_sum = {1'b0, acc} + {1'b0, frac_a};

    // Resync wins over a period expiry that lands on the same cycle.
    assign expire  = i_baud_os_en && !resync && (count == len_m1);
    assign apply   = pending && (expire || !i_baud_os_en || resync);

    // Config handshake: capture into the shadow, hold ready low until the
    // copy to the active registers has happened.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            div_s       <= '0;
            frac_s      <= '0;
            pending     <= 1'b0;
            o_cfg_ready <= 1'b1;
        end else if (i_cfg_valid && o_cfg_ready) begin
            div_s       <= i_divisor;
            frac_s      <= i_frac;
            pending     <= 1'b1;
            o_cfg_ready <= 1'b0;
        end else if (apply) begin
            pending     <= 1'b0;
        end else if (!pending && !o_cfg_ready) begin
            o_cfg_ready <= 1'b1;
        end
    end

    // Period counter, fractional accumulator, oversample index and tick outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            div_a      <= DIV_WIDTH'(DEFAULT_DIV);
            frac_a     <= FRAC_WIDTH'(DEFAULT_FRAC);
            count      <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            o_os_count <= '0;
            o_baud_os  <= 1'b0;
            o_baud     <= 1'b0;
        end else begin
            o_baud_os <= expire;
            o_baud    <= expire && i_baud_en && (o_os_count == OSW'(OSR-1));
            if (apply) begin
                div_a  <= div_s;
                frac_a <= frac_s;
            end
            if (!i_baud_os_en || resync) begin
                count      <= '0;
                acc        <= '0;
                carry      <= 1'b0;
                o_os_count <= '0;
            end else if (expire) begin
                count <= '0;
                if (apply) begin
                    // New settings start from a clean fractional phase.
                    acc   <= '0;
                    carry <= 1'b0;
                end else begin
                    acc   <= acc_sum[FRAC_WIDTH-1:0];
                    carry <= acc_sum[FRAC_WIDTH];
                end
                if (o_os_count == OSW'(OSR-1))
                    o_os_count <= '0;
                else
                    o_os_count <= o_os_count + OSW'(1);
            end else begin
                count <= count + (DIV_WIDTH+1)'(1);
            end
        end
    end

endmodule
